// File: rtl/serial_sub_pkg.sv
// Purpose : shared types and constants for the bit-serial subtractor.
// Contents: FSM state enum (IDLE/SHIFT/DONE), default operand width,
//           signed-overflow helper used when SERIAL_SUB_OVERFLOW_EN is defined.
package serial_sub_pkg;

  // Default operand/result width; legal range for the subtractor is 2..64.
  localparam int SUB_WIDTH_DEFAULT = 32;
  localparam int SUB_WIDTH_MIN     = 2;
  localparam int SUB_WIDTH_MAX     = 64;

  // IDLE : waiting for operands (o_ready high)
  // SHIFT: one bit per cycle, LSB first
  // DONE : result presented until the consumer takes it (o_valid high)
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_e;

  // Two's-complement overflow of A-B, evaluated from the sign bits only:
  // operands of differing sign whose result sign differs from the minuend.
  function automatic logic sub_signed_ovf(input logic a_msb,
                                          input logic b_msb,
                                          input logic d_msb);
    return (a_msb ^ b_msb) & (d_msb ^ a_msb);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_sub.sv
// Purpose : combinational 1-bit full subtractor, the per-bit stage of the
//           serial subtractor. Latency 0, no flow control.
// Ports   : a (minuend bit), b (subtrahend bit), bin (borrow in),
//           diff (difference bit), bout (borrow out).
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Purpose : bit-serial unsigned subtractor, o_data = A-B mod 2^WIDTH with
//           borrow-out; one bit per cycle LSB-first through a full_subtractor.
// Latency : o_valid rises WIDTH cycles after the accepting edge; one job in
//           flight, o_ready only in IDLE.
// Backpr. : result held in DONE until i_ready; next accept one cycle later.
// Ports   : i_clk, i_rst_n (async active-low), i_valid/o_ready/i_data_a/
//           i_data_b (operand side), o_valid/i_ready/o_data/o_borrow (result
//           side), o_overflow (only when SERIAL_SUB_OVERFLOW_EN is defined).
// Config  : `define SERIAL_SUB_OVERFLOW_EN adds the registered signed-overflow
//           flag; without it the port and its logic are absent.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  // operand request
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data_a,
  input  logic [WIDTH-1:0] i_data_b,
  // result
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
`ifdef SERIAL_SUB_OVERFLOW_EN
  output logic             o_overflow,
`endif
  output logic             o_borrow
);

  // Counter just wide enough to hold WIDTH-1.
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  sub_state_e       state_q,  state_d;
  logic [WIDTH-1:0] a_q,      a_d;       // minuend, shifted right each bit
  logic [WIDTH-1:0] b_q,      b_d;       // subtrahend, shifted right each bit
  logic [WIDTH-1:0] res_q,    res_d;     // partial difference, filled from MSB
  logic             bin_q,    bin_d;     // borrow carried into the next bit
  logic [CNT_W-1:0] cnt_q,    cnt_d;     // index of the bit being processed
  logic [WIDTH-1:0] data_q,   data_d;    // published result
  logic             borrow_q, borrow_d;  // published borrow-out
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             ovf_q,    ovf_d;     // published signed overflow
`endif

  // ---------------------------------------------------------------------
  // Per-bit stage: always looks at the current LSBs of the operand shifters.
  // ---------------------------------------------------------------------
  logic fs_a;
  logic fs_b;
  logic fs_diff;
  logic fs_bout;

  assign fs_a = a_q[0];
  assign fs_b = b_q[0];

  full_subtractor u_full_sub (
    .a    (fs_a),
    .b    (fs_b),
    .bin  (bin_q),
    .diff (fs_diff),
    .bout (fs_bout)
  );

  // Partial result after this cycle's bit: new diff enters at the MSB, so
  // after WIDTH shifts bit 0 has travelled down to position 0.
  logic [WIDTH-1:0] res_shifted;
  assign res_shifted = {fs_diff, res_q[WIDTH-1:1]};

  // ---------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    bin_d    = bin_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif

    unique case (state_q)
      IDLE: begin
        // Operands are captured only here; everything else ignores them.
        if (i_valid) begin
          a_d     = i_data_a;
          b_d     = i_data_b;
          res_d   = '0;
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = res_shifted;
        bin_d = fs_bout;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          // Last bit: publish the completed word in the same edge that
          // enters DONE, so outputs never show a partial result.
          cnt_d    = '0;
          data_d   = res_shifted;
          borrow_d = fs_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
          // The operand LSBs are now the original sign bits and fs_diff
          // is the result sign.
          ovf_d    = sub_signed_ovf(fs_a, fs_b, fs_diff);
`endif
          state_d  = DONE;
        end
      end

      DONE: begin
        // Return to IDLE on the handshake; acceptance is only possible from
        // IDLE, so a new job starts one cycle later at the earliest.
        if (i_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Registers (async reset discards any in-flight job)
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      bin_q    <= 1'b0;
      cnt_q    <= '0;
      data_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      borrow_q <= borrow_d;
    end
  end

`ifdef SERIAL_SUB_OVERFLOW_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign o_overflow = ovf_q;
`endif

  // ---------------------------------------------------------------------
  // Outputs: decoded from the state register so reset acts immediately.
  // ---------------------------------------------------------------------
  assign o_ready  = (state_q == IDLE);
  assign o_valid  = (state_q == DONE);
  assign o_data   = data_q;
  assign o_borrow = borrow_q;

endmodule
